bcd_display_counter: RTL

Parametrised up/down BCD counter driving a bank of active-low 7-segment displays. It extends the two-digit preload counter to DIGITS digits and adds a registered limit load, wrap and bounce modes, and tick/terminal strobes. Counting is native BCD with per-digit carry and borrow, so no binary divide or modulo is used. It sits between the board switches and buttons and the DE-series HEX displays, clocked by the 50 MHz board clock.

---
 rtl/bcd_display_counter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_display_counter.sv
// Up/down multi-digit BCD counter with limit load, wrap/bounce modes and
// registered active-low 7-segment outputs, one display per digit.
module bcd_display_counter #(
  parameter int DIGITS = 2,
  parameter int DIV    = 12499999
) (
  input  logic                  clk_50MHz,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   limit,
  input  logic                  dir_toggle,
  input  logic                  bounce,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  count_up,
  output logic                  tick,
  output logic                  wrap
);

  localparam int              W     = 4 * DIGITS;
  localparam int              DW    = (DIV < 2) ? 1 : $clog2(DIV + 1);
  localparam logic [DW-1:0]   DIV_C = DW'(DIV);

  logic [DW-1:0]      r_div;
  logic [W-1:0]       r_limit;
  logic [W-1:0]       r_count;
  logic               r_up;
  logic               r_tick;
  logic               r_wrap;
  logic [7*DIGITS-1:0] r_seg;

  logic [W-1:0]       w_limit_sat;
  logic [W-1:0]       w_cnt_inc;
  logic [W-1:0]       w_cnt_dec;
  logic [W-1:0]       w_lim_dec;
  logic [DIGITS-1:0]  w_inc_carry;
  logic [DIGITS-1:0]  w_dec_borrow;
  logic [DIGITS-1:0]  w_lim_borrow;
  logic [7*DIGITS-1:0] w_seg_next;

  logic [DW-1:0]      w_div_next;
  logic [W-1:0]       w_limit_next;
  logic [W-1:0]       w_count_next;
  logic               w_up_next;
  logic               w_tick_next;
  logic               w_wrap_next;
  logic               w_reverse;

  logic               w_at_top;
  logic               w_at_zero;
  logic               w_lim_zero;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0000111;
    endcase
    return s;
  endfunction

  // Packed BCD with valid digits orders the same as the binary value, so a
  // plain magnitude compare against the limit is exact.
  assign w_at_top   = (r_count >= r_limit);
  assign w_at_zero  = (r_count == '0);
  assign w_lim_zero = (r_limit == '0);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_cd;
      logic [3:0] w_ld;
      logic [3:0] w_in;
      assign w_cd = r_count[4*gi +: 4];
      assign w_ld = r_limit[4*gi +: 4];
      assign w_in = limit[4*gi +: 4];

      assign w_limit_sat[4*gi +: 4] = (w_in > 4'd9) ? 4'd9 : w_in;

      // Carry/borrow ripple: a digit moves only when every lower digit rolls.
      if (gi == 0) begin : g_lsd
        assign w_inc_carry[gi]  = 1'b1;
        assign w_dec_borrow[gi] = 1'b1;
        assign w_lim_borrow[gi] = 1'b1;
      end else begin : g_upper
        assign w_inc_carry[gi]  = w_inc_carry[gi-1]  && (r_count[4*(gi-1) +: 4] == 4'd9);
        assign w_dec_borrow[gi] = w_dec_borrow[gi-1] && (r_count[4*(gi-1) +: 4] == 4'd0);
        assign w_lim_borrow[gi] = w_lim_borrow[gi-1] && (r_limit[4*(gi-1) +: 4] == 4'd0);
      end

      assign w_cnt_inc[4*gi +: 4] = !w_inc_carry[gi]  ? w_cd :
                                    (w_cd == 4'd9)    ? 4'd0 : w_cd + 4'd1;
      assign w_cnt_dec[4*gi +: 4] = !w_dec_borrow[gi] ? w_cd :
                                    (w_cd == 4'd0)    ? 4'd9 : w_cd - 4'd1;
      assign w_lim_dec[4*gi +: 4] = !w_lim_borrow[gi] ? w_ld :
                                    (w_ld == 4'd0)    ? 4'd9 : w_ld - 4'd1;

      assign w_seg_next[7*gi +: 7] = seg7(w_cd);
    end
  endgenerate

  always_comb begin
    w_div_next   = r_div;
    w_limit_next = r_limit;
    w_count_next = r_count;
    w_up_next    = r_up;
    w_tick_next  = 1'b0;
    w_wrap_next  = 1'b0;
    w_reverse    = 1'b0;
    if (load) begin
      w_limit_next = w_limit_sat;
      w_count_next = '0;
      w_div_next   = '0;
    end else begin
      if (ena) begin
        if (r_div == DIV_C) begin
          w_div_next  = '0;
          w_tick_next = 1'b1;
          if (r_up) begin
            if (w_at_top) begin
              w_wrap_next = 1'b1;
              if (bounce) begin
                w_up_next    = 1'b0;
                w_reverse    = 1'b1;
                w_count_next = w_lim_zero ? '0 : w_lim_dec;
              end else begin
                w_count_next = '0;
              end
            end else begin
              w_count_next = w_cnt_inc;
            end
          end else begin
            if (w_at_zero) begin
              w_wrap_next = 1'b1;
              if (bounce) begin
                w_up_next    = 1'b1;
                w_reverse    = 1'b1;
                w_count_next = w_lim_zero ? '0 : W'(1);
              end else begin
                w_count_next = r_limit;
              end
            end else begin
              w_count_next = w_cnt_dec;
            end
          end
        end else begin
          w_div_next = r_div + DW'(1);
        end
      end
      // A bounce reversal already sets the direction; a coincident toggle is dropped.
      if (dir_toggle && !w_reverse) begin
        w_up_next = ~r_up;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_limit <= {DIGITS{4'h9}};
      r_count <= '0;
      r_up    <= 1'b1;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_seg   <= {DIGITS{7'b1000000}};
    end else begin
      r_div   <= w_div_next;
      r_limit <= w_limit_next;
      r_count <= w_count_next;
      r_up    <= w_up_next;
      r_tick  <= w_tick_next;
      r_wrap  <= w_wrap_next;
      r_seg   <= w_seg_next;
    end
  end

  assign count    = r_count;
  assign seg      = r_seg;
  assign count_up = r_up;
  assign tick     = r_tick;
  assign wrap     = r_wrap;

endmodule
